bcd_to_bin_converter: RTL and testbench

Sequential reverse double-dabble converter: accepts a packed BCD number and produces its unsigned binary value by iterated shift-right and subtract-3 correction. It is the inverse of the binary-to-BCD shift-and-add stage and sits on the input side of the datapath, where keypad or display-format BCD values re-enter binary arithmetic. It uses a start/busy/done handshake and flags invalid BCD digits.

---
 rtl/bcd_to_bin_converter_pkg.sv | 20 ++
 rtl/bcd_to_bin_converter_sub3.sv | 14 +
 rtl/bcd_to_bin_converter.sv | 128 ++++++++++++
 tb/tb_bcd_to_bin_converter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_converter_pkg.sv
// Shared definitions for the BCD-to-binary converter.
// Holds the controller state encoding, the per-digit correction constants
// used by the reverse double-dabble step, and the BCD digit validity limit.
package bcd_to_bin_converter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A digit at or above this value after a right shift had a carry-in
    // worth 8 that must become 5 (decimal weight), hence subtract 3.
    localparam logic [3:0] SUB3_THRESH = 4'd8;
    localparam logic [3:0] SUB3_VALUE  = 4'd3;

    // Largest legal BCD digit.
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_to_bin_converter_sub3.sv
// Combinational single-digit corrector for reverse double-dabble.
// Ports:
//   din  [3:0]  digit after the right shift
//   dout [3:0]  din - 3 when din >= 8, otherwise din (4-bit, no borrow out)
module bcd_digit_sub3
    import bcd_to_bin_converter_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= SUB3_THRESH) ? (din - SUB3_VALUE) : din;

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// A conversion shifts {bcd, bin} right BIN_W times, correcting every BCD
// digit that lands at >= 8 by subtracting 3. Inputs with a digit > 9 are
// rejected immediately with err set and a zero result.
// Ports:
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset
//   start    conversion request, only honoured in IDLE
//   bcd_in   packed BCD input, digit 0 in [3:0], sampled on the accept edge
//   busy     high whenever the converter is not IDLE
//   done     one-cycle pulse marking bin_out/err valid
//   err      input contained an invalid digit; held until the next accept
//   bin_out  binary result; held until the next accept
module bcd_to_bin_converter
    import bcd_to_bin_converter_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [BIN_W-1:0]    bin_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state_reg, state_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic [BIN_W-1:0]   bin_reg, bin_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [BIN_W-1:0]   bin_out_reg, bin_out_next;
    logic               err_reg, err_next;

    logic [DIGITS-1:0]  digit_bad;
    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   bcd_corr;
    logic [BIN_W-1:0]   bin_shift;

    // One shift step: bcd LSB drops into the binary MSB.
    assign bcd_shift = bcd_reg >> 1;
    assign bin_shift = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_bad[gi] = (bcd_in[4*gi +: 4] > BCD_MAX);

            bcd_digit_sub3 u_sub3 (
                .din  (bcd_shift[4*gi +: 4]),
                .dout (bcd_corr[4*gi +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            bcd_reg     <= '0;
            bin_reg     <= '0;
            count_reg   <= '0;
            bin_out_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bcd_reg     <= bcd_next;
            bin_reg     <= bin_next;
            count_reg   <= count_next;
            bin_out_reg <= bin_out_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bcd_next     = bcd_reg;
        bin_next     = bin_reg;
        count_next   = count_reg;
        bin_out_next = bin_out_reg;
        err_next     = err_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (|digit_bad) begin
                        // Reject without shifting; result is reported as zero.
                        bin_out_next = '0;
                        err_next     = 1'b1;
                        state_next   = DONE;
                    end else begin
                        bcd_next   = bcd_in;
                        bin_next   = '0;
                        count_next = CNT_W'(BIN_W);
                        err_next   = 1'b0;
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                bcd_next   = bcd_corr;
                bin_next   = bin_shift;
                count_next = count_reg - CNT_W'(1);
                // Last shift: publish the freshly shifted value directly.
                if (count_reg == CNT_W'(1)) begin
                    bin_out_next = bin_shift;
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign err     = err_reg;
    assign bin_out = bin_out_reg;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
module tb_bcd_to_bin_converter;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  bin_out;

    int total  = 0;
    int passed = 0;

    bcd_to_bin_converter #(.DIGITS(3), .BIN_W(10)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, got, exp);
    endtask

    // Reference: decimal value from the digits with plain arithmetic.
    task automatic ref_model(input logic [11:0] v, output logic [9:0] b, output logic e, output int lat);
        int acc;
        int p;
        int d;
        acc = 0;
        p = 1;
        e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = int'((v >> (4 * i)) & 12'hF);
            if (d > 9) e = 1'b1;
            acc += d * p;
            p *= 10;
        end
        b   = e ? 10'd0 : 10'(acc);
        lat = e ? 1 : 11;
    endtask

    // Called at a falling edge; returns at the falling edge after done.
    task automatic convert(input logic [11:0] v, input logic [9:0] eb, input logic ee, input int el);
        int   n;
        logic busy_ok;
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 12'($urandom);
        @(negedge clk);
        n = 1;
        busy_ok = 1'b1;
        if (!ee) check("err_cleared_on_accept", 32'(err), 32'd0);
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(n), 32'(el));
        check("bin_out", 32'(bin_out), 32'(eb));
        check("err", 32'(err), 32'(ee));
        check("busy_during", 32'(busy_ok & busy), 32'd1);
        $display("txn bcd=%03h bin=%0d err=%0d latency=%0d", v, bin_out, err, n);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [11:0] rv;
        logic [9:0]  rb;
        logic        re;
        int          rl;
        int          ndone;
        logic [9:0]  bin_at_done;
        logic [3:0]  dg;

        vecs[0] = '{12'h000, 10'd0,   1'b0, 11};
        vecs[1] = '{12'h999, 10'd999, 1'b0, 11};
        vecs[2] = '{12'h255, 10'd255, 1'b0, 11};
        vecs[3] = '{12'h100, 10'd100, 1'b0, 11};
        vecs[4] = '{12'h1A3, 10'd0,   1'b1, 1};
        vecs[5] = '{12'h042, 10'd42,  1'b0, 11};
        vecs[6] = '{12'hF00, 10'd0,   1'b1, 1};
        vecs[7] = '{12'h508, 10'd508, 1'b0, 11};

        rstn   = 1'b0;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_bin_out", 32'(bin_out), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Table vectors back to back: each start lands in the first IDLE cycle.
        for (int i = 0; i < 8; i++) begin
            convert(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].lat);
        end

        // err holds through idle cycles after a rejected input.
        convert(12'h0B0, 10'd0, 1'b1, 1);
        repeat (3) @(negedge clk);
        check("err_held_idle", 32'(err), 32'd1);

        // Randomized against the arithmetic model.
        for (int k = 0; k < 40; k++) begin
            rv = 12'h000;
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(0, 7) == 0) dg = 4'($urandom_range(10, 15));
                else dg = 4'($urandom_range(0, 9));
                rv = rv | (12'(dg) << (4 * j));
            end
            ref_model(rv, rb, re, rl);
            convert(rv, rb, re, rl);
        end

        // start during SHIFT is ignored.
        bcd_in = 12'h321;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        bcd_in = 12'h777;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        bin_at_done = 10'd0;
        for (int c = 0; c < 30; c++) begin
            if (done) begin
                ndone++;
                bin_at_done = bin_out;
            end
            @(negedge clk);
        end
        check("busy_start_ignored_dones", 32'(ndone), 32'd1);
        check("busy_start_ignored_bin", 32'(bin_at_done), 32'd321);
        $display("txn bcd=321 (777 during shift) dones=%0d bin=%0d", ndone, bin_at_done);

        // Asynchronous reset mid-conversion.
        bcd_in = 12'h999;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        check("async_reset_err", 32'(err), 32'd0);
        check("async_reset_bin_out", 32'(bin_out), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("aborted_no_done", 32'(ndone), 32'd0);
        $display("txn bcd=999 aborted by reset dones=%0d", ndone);
        convert(12'h010, 10'd10, 1'b0, 11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
